alu_exec_unit: RTL

Execute-stage ALU that consumes the operand pair and enable produced by the ALU operand-select stage (DATA0, DATA1, ALU_EN) together with OPCODE/FUNCT3/FUNCT7 bit 5. It computes the RV32I integer result and delivers it to writeback over a valid/ready handshake. Shifts run on an iterative 1-bit-per-cycle shifter by default, under a small FSM. A single-cycle barrel shifter is available as a compile-time option.

---
 rtl/alu_exec_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// RV32I execute-stage ALU with a valid/ready result port and an iterative 1-bit/cycle shifter.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec_unit (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] DATA0,
    input  logic [31:0] DATA1,
    input  logic        ALU_EN,
    input  logic [6:0]  OPCODE,
    input  logic [2:0]  FUNCT3,
    input  logic        FUNCT7_5,
    input  logic [4:0]  RD_IN,
    input  logic        FLUSH,
    output logic        IN_READY,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] RESULT,
    output logic [4:0]  RD_OUT,
    output logic        BUSY
);

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;

    typedef enum logic [3:0] {
        OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd
    } alu_op_e;

`ifdef ALU_FAST_SHIFT_EN
    typedef enum logic [1:0] {StIdle, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  rd_q, rd_d;
    alu_op_e     op;
    logic [31:0] alu_result;
    logic        is_shift;
    logic        accept;
    logic [4:0]  shamt;

    assign shamt = DATA1[4:0];

    // Only OP and OP-IMM decode FUNCT3; every other opcode is an address/immediate add.
    always_comb begin
        op = OpAdd;
        if (OPCODE == OpcOp || OPCODE == OpcOpImm) begin
            unique case (FUNCT3)
                3'b000:  op = (OPCODE == OpcOp && FUNCT7_5) ? OpSub : OpAdd;
                3'b001:  op = OpSll;
                3'b010:  op = OpSlt;
                3'b011:  op = OpSltu;
                3'b100:  op = OpXor;
                3'b101:  op = FUNCT7_5 ? OpSra : OpSrl;
                3'b110:  op = OpOr;
                3'b111:  op = OpAnd;
                default: op = OpAdd;
            endcase
        end
    end

    assign is_shift = (op == OpSll) || (op == OpSrl) || (op == OpSra);

    always_comb begin
        alu_result = DATA0 + DATA1;
        unique case (op)
            OpSub:   alu_result = DATA0 - DATA1;
            OpSlt:   alu_result = {31'b0, $signed(DATA0) < $signed(DATA1)};
            OpSltu:  alu_result = {31'b0, DATA0 < DATA1};
            OpXor:   alu_result = DATA0 ^ DATA1;
            OpOr:    alu_result = DATA0 | DATA1;
            OpAnd:   alu_result = DATA0 & DATA1;
`ifdef ALU_FAST_SHIFT_EN
            OpSll:   alu_result = DATA0 << shamt;
            OpSrl:   alu_result = DATA0 >> shamt;
            OpSra:   alu_result = $unsigned($signed(DATA0) >>> shamt);
`else
            // Iterative path only reaches here for shamt == 0.
            OpSll, OpSrl, OpSra: alu_result = DATA0;
`endif
            default: alu_result = DATA0 + DATA1;
        endcase
    end

    assign IN_READY  = ~FLUSH & ((state_q == StIdle) | ((state_q == StDone) & OUT_READY));
    assign accept    = ALU_EN & IN_READY;
    assign OUT_VALID = (state_q == StDone);
    assign RESULT    = result_q;
    assign RD_OUT    = rd_q;

`ifdef ALU_FAST_SHIFT_EN
    assign BUSY = 1'b0;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        rd_d     = rd_q;
        if (FLUSH) begin
            state_d = StIdle;
        end else if (accept) begin
            result_d = alu_result;
            rd_d     = RD_IN;
            state_d  = StDone;
        end else if (state_q == StDone && OUT_READY) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= StIdle;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end
`else
    logic [31:0] sh_q, sh_d, sh_next;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  rd_pend_q, rd_pend_d;
    logic        left_q, left_d;
    logic        fill_q, fill_d;

    // fill_q latches the original sign for SRA so every step shifts in the same bit.
    assign sh_next = left_q ? {sh_q[30:0], 1'b0} : {fill_q, sh_q[31:1]};
    assign BUSY    = (state_q == StShift);

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        rd_d      = rd_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        rd_pend_d = rd_pend_q;
        left_d    = left_q;
        fill_d    = fill_q;
        if (FLUSH) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        if (is_shift && shamt != 5'd0) begin
                            sh_d      = DATA0;
                            cnt_d     = shamt;
                            rd_pend_d = RD_IN;
                            left_d    = (op == OpSll);
                            fill_d    = (op == OpSra) & DATA0[31];
                            state_d   = StShift;
                        end else begin
                            result_d = alu_result;
                            rd_d     = RD_IN;
                            state_d  = StDone;
                        end
                    end else if (state_q == StDone && OUT_READY) begin
                        state_d = StIdle;
                    end
                end
                StShift: begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        result_d = sh_next;
                        rd_d     = rd_pend_q;
                        state_d  = StDone;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            result_q  <= '0;
            rd_q      <= '0;
            sh_q      <= '0;
            cnt_q     <= '0;
            rd_pend_q <= '0;
            left_q    <= 1'b0;
            fill_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            left_q    <= left_d;
            fill_q    <= fill_d;
        end
    end
`endif

endmodule
